// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: opcodes, instruction fields,
// FSM state encoding and the error result constant.
package alu_pkg;

    localparam int unsigned OP_CMP = 0;
    localparam int unsigned OP_ADD = 1;
    localparam int unsigned OP_SUB = 2;
    localparam int unsigned OP_DIV = 3;
    localparam int unsigned OP_MUL = 4;

    localparam int unsigned INSTR_W = 12;
    localparam int unsigned OP_LSB  = 9;
    localparam int unsigned RSV_BIT = 8;
    localparam int unsigned A_MSB   = 7;
    localparam int unsigned A_LSB   = 4;
    localparam int unsigned B_MSB   = 3;
    localparam int unsigned B_LSB   = 0;

    localparam logic [7:0] ERR_RESULT = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StExec,
        StWait,
        StDone
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot operation strobes gated by en, plus an illegal flag
// that reflects the opcode alone.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int unsigned OPW = 3
) (
    input  logic [OPW-1:0] opcode,
    input  logic           en,
    output logic           op_cmp,
    output logic           op_add,
    output logic           op_sub,
    output logic           op_div,
    output logic           op_mul,
    output logic           illegal
);

    always_comb begin
        op_cmp  = 1'b0;
        op_add  = 1'b0;
        op_sub  = 1'b0;
        op_div  = 1'b0;
        op_mul  = 1'b0;
        illegal = 1'b0;
        unique case (opcode)
            OPW'(OP_CMP): op_cmp = en;
            OPW'(OP_ADD): op_add = en;
            OPW'(OP_SUB): op_sub = en;
            OPW'(OP_DIV): op_div = en;
            OPW'(OP_MUL): op_mul = en;
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer in front of the ALU datapath: one instruction in flight, ldA/ldB/op strobes,
// Y capture and result handshake. Define ALU_SEQ_CTRL_DIVZ_EN to trap DIV with B==0.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned OPW         = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [7:0]          res_data,
    output logic                res_err,
    output logic [INSTR_W-1:0]  Datain,
    output logic                ldA,
    output logic                ldB,
    output logic                aCmp,
    output logic                aAdd,
    output logic                aSub,
    output logic                aDiv,
    output logic                aMul,
    input  logic [7:0]          Y
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   datain_q, datain_d;
    logic [7:0]           res_data_q, res_data_d;
    logic                 res_err_q, res_err_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [OPW-1:0]       op_sel;
    logic                 illegal;

    // In IDLE the decoder screens the incoming opcode; afterwards it decodes the latched one.
    assign op_sel = (state_q == StIdle) ? instr[OP_LSB +: OPW] : datain_q[OP_LSB +: OPW];

    alu_op_decode #(
        .OPW (OPW)
    ) u_decode (
        .opcode  (op_sel),
        .en      (state_q == StExec),
        .op_cmp  (aCmp),
        .op_add  (aAdd),
        .op_sub  (aSub),
        .op_div  (aDiv),
        .op_mul  (aMul),
        .illegal (illegal)
    );

`ifdef ALU_SEQ_CTRL_DIVZ_EN
    logic divz;
    assign divz = (instr[OP_LSB +: OPW] == OPW'(OP_DIV)) && (instr[B_MSB:B_LSB] == '0);
`endif

    always_comb begin
        state_d    = state_q;
        datain_d   = datain_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    datain_d = instr;
                    if (illegal) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = StDone;
`ifdef ALU_SEQ_CTRL_DIVZ_EN
                    end else if (divz) begin
                        res_data_d = ERR_RESULT;
                        res_err_d  = 1'b1;
                        state_d    = StDone;
`endif
                    end else begin
                        state_d = StLoadA;
                    end
                end
            end
            StLoadA: state_d = StLoadB;
            StLoadB: state_d = StExec;
            StExec: begin
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_data_d = Y;
                    res_err_d  = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            datain_q   <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            datain_q   <= datain_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign instr_ready = (state_q == StIdle);
    assign res_valid   = (state_q == StDone);
    assign ldA         = (state_q == StLoadA);
    assign ldB         = (state_q == StLoadB);
    assign Datain      = datain_q;
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small ALU datapath model driving Y.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        res_err;
    logic [11:0] datain;
    logic        ldA, ldB;
    logic        aCmp, aAdd, aSub, aDiv, aMul;
    logic [7:0]  y;

    logic [4:0]  ops;
    int unsigned op_cnt [5];
    int unsigned ld_cnt;
    int unsigned n_total;
    int unsigned n_pass;

    alu_seq_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .Datain      (datain),
        .ldA         (ldA),
        .ldB         (ldB),
        .aCmp        (aCmp),
        .aAdd        (aAdd),
        .aSub        (aSub),
        .aDiv        (aDiv),
        .aMul        (aMul),
        .Y           (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ops = {aMul, aDiv, aSub, aAdd, aCmp};

    // Datapath model: operand registers plus one registered result stage.
    logic [3:0] ra, rb;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
            y  <= '0;
        end else begin
            if (ldA) ra <= datain[7:4];
            if (ldB) rb <= datain[3:0];
            if (aCmp) y <= {6'd0, ra > rb, ra == rb};
            if (aAdd) y <= 8'(ra) + 8'(rb);
            if (aSub) y <= 8'(ra) - 8'(rb);
            if (aDiv) y <= (rb == 4'd0) ? 8'hFF : 8'(ra) / 8'(rb);
            if (aMul) y <= 8'(ra) * 8'(rb);
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) op_cnt[i] = 0;
        ld_cnt = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) if (ops[i]) op_cnt[i] = op_cnt[i] + 1;
        if (ldA || ldB) ld_cnt = ld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int unsigned strobe_total();
        int unsigned s = ld_cnt;
        for (int i = 0; i < 5; i++) s += op_cnt[i];
        return s;
    endfunction

    // Full legal sequence with res_ready raised on the first DONE cycle.
    task automatic run_legal(input logic [11:0] ins, input logic [7:0] exp_y, input string tag);
        int unsigned c0 [5];
        logic [4:0]  exp_oh;
        exp_oh = 5'b00001 << ins[11:9];
        for (int i = 0; i < 5; i++) c0[i] = op_cnt[i];
        res_ready   = 1'b0;
        instr       = ins;
        instr_valid = 1'b1;
        check({tag, "_rdy0"}, 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        check({tag, "_c1_ldA"}, 32'(ldA), 32'd1);
        check({tag, "_c1_ldB"}, 32'(ldB), 32'd0);
        check({tag, "_c1_datain"}, 32'(datain), 32'(ins));
        check({tag, "_c1_rdy"}, 32'(instr_ready), 32'd0);
        @(negedge clk);
        check({tag, "_c2_ldB"}, 32'(ldB), 32'd1);
        check({tag, "_c2_ldA"}, 32'(ldA), 32'd0);
        check({tag, "_c2_ops"}, 32'(ops), 32'd0);
        @(negedge clk);
        check({tag, "_c3_ops"}, 32'(ops), 32'(exp_oh));
        check({tag, "_c3_ldB"}, 32'(ldB), 32'd0);
        @(negedge clk);
        check({tag, "_c4_ops"}, 32'(ops), 32'd0);
        check({tag, "_c4_valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        check({tag, "_c5_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_c5_data"}, 32'(res_data), 32'(exp_y));
        check({tag, "_c5_err"}, 32'(res_err), 32'd0);
        check({tag, "_c5_datain"}, 32'(datain), 32'(ins));
        res_ready = 1'b1;
        @(negedge clk);
        check({tag, "_c6_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_c6_rdy"}, 32'(instr_ready), 32'd1);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            check({tag, "_opcnt"}, op_cnt[i] - c0[i], 32'(exp_oh[i]));
    endtask

    // Opcode that must bypass the datapath and finish on cycle 1 with an error result.
    task automatic run_trap(input logic [11:0] ins, input logic [7:0] exp_y, input string tag);
        int unsigned s0;
        s0          = strobe_total();
        res_ready   = 1'b1;
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check({tag, "_c1_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_c1_data"}, 32'(res_data), 32'(exp_y));
        check({tag, "_c1_err"}, 32'(res_err), 32'd1);
        check({tag, "_c1_ldA"}, 32'(ldA), 32'd0);
        @(negedge clk);
        check({tag, "_c2_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_c2_rdy"}, 32'(instr_ready), 32'd1);
        check({tag, "_strobes"}, strobe_total() - s0, 32'd0);
        res_ready = 1'b0;
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        res_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 32'(instr_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        check("rst_datain", 32'(datain), 32'd0);
        check("rst_strobes", 32'({ldA, ldB, ops}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_legal(12'h235, 8'h08, "add");
        run_legal(12'h8FF, 8'hE1, "mul");
        run_legal(12'h055, 8'h01, "cmp");
        run_legal(12'h683, 8'h02, "div");
        run_trap(12'hC12, 8'h00, "ill6");
        run_trap(12'hFAB, 8'h00, "ill7");

        // Backpressure; bit 8 set must not disturb decode (SUB 7-2).
        instr       = 12'h572;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_sub", 32'(aSub), 32'd1);
        repeat (2) @(negedge clk);
        check("bp_valid", 32'(res_valid), 32'd1);
        check("bp_data", 32'(res_data), 32'h05);
        instr       = 12'h235;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_data", 32'(res_data), 32'h05);
            check("bp_hold_err", 32'(res_err), 32'd0);
            check("bp_hold_rdy", 32'(instr_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_idle_rdy", 32'(instr_ready), 32'd1);
        check("bp_idle_valid", 32'(res_valid), 32'd0);
        check("bp_idle_ldA", 32'(ldA), 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        check("bp_next_ldA", 32'(ldA), 32'd1);
        check("bp_next_datain", 32'(datain), 32'h235);
        repeat (4) @(negedge clk);
        check("bp_next_data", 32'(res_data), 32'h08);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset asserted while the SUB strobe is high.
        instr       = 12'h463;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rstx_sub_before", 32'(aSub), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstx_sub_async", 32'(aSub), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstx_rdy", 32'(instr_ready), 32'd1);
        check("rstx_valid", 32'(res_valid), 32'd0);
        check("rstx_datain", 32'(datain), 32'd0);

`ifdef ALU_SEQ_CTRL_DIVZ_EN
        run_trap(12'h690, 8'hFF, "divz");
`else
        run_legal(12'h690, 8'hFF, "divz");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller directly upstream of the ALU datapath.
- Accepts one 12-bit instruction per valid/ready handshake and drives the datapath Datain bus, the ldA/ldB load strobes and one operation strobe.
- Waits for the datapath's registered Y, captures it, and returns it through a valid/ready result handshake.
- Exactly one instruction is in flight at a time.

Parameters:
- WAIT_CYCLES, 1, cycles between operation strobe and Y capture (legal 1..15); 1 matches the datapath's single registered result stage.
- OPW, 3, opcode field width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept an instruction
- instr  in  12  [11:9] opcode, [8] reserved (ignored), [7:4] operand A, [3:0] operand B
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured result
- res_err  out  1  result flagged as error
- Datain  out  12  datapath data bus, carries the latched instruction
- ldA  out  1  datapath load-A strobe
- ldB  out  1  datapath load-B strobe
- aCmp, aAdd, aSub, aDiv, aMul  out  1 each  operation strobes, one-hot or all zero
- Y  in  8  datapath result

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state IDLE; instr_ready=1; res_valid=0; res_data=0; res_err=0; Datain=0.
  - All strobes 0; wait counter 0.
- Opcodes: 0 CMP, 1 ADD, 2 SUB, 3 DIV, 4 MUL; 5-7 illegal.
- States and transitions:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr into Datain and go to LOAD_A.
  - LOAD_A: ldA=1 for exactly one cycle, then LOAD_B.
  - LOAD_B: ldB=1 for exactly one cycle, then EXEC.
  - EXEC: the decoded op strobe is 1 for exactly one cycle; counter loads WAIT_CYCLES; then WAIT.
  - WAIT: decrement the counter. At counter==1, capture Y into res_data, set res_err=0, go to DONE.
  - DONE: res_valid=1. On res_ready, go to IDLE and clear res_valid.
  - Illegal opcode in IDLE accept: go directly to DONE with res_data=0, res_err=1. No ld or op strobe is ever asserted.
- Timing and handshakes:
  - Latency with WAIT_CYCLES=1: accept edge at cycle 0, ldA in cycle 1, ldB in cycle 2, op strobe in cycle 3, capture at the end of cycle 4, res_valid from cycle 5.
  - instr_ready=0 in every state except IDLE, so there is no pipelining.
  - Datain holds the latched value from LOAD_A through DONE.
  - res_data and res_err are stable while res_valid=1 && !res_ready.
- Simultaneous events and boundaries:
  - res_ready already high on the first DONE cycle: a one-cycle res_valid pulse; IDLE on the next cycle.
  - instr_valid high during DONE is ignored until IDLE.
  - Reset mid-operation: strobes drop asynchronously and the in-flight instruction is discarded.
  - Reserved bit [8] has no effect on decode.

Optional Feature:
- Macro: ALU_SEQ_CTRL_DIVZ_EN.
- Defined: an opcode DIV with B==0 is treated like an illegal opcode. It goes to DONE with res_data=8'hFF, res_err=1, and no datapath strobes.
- Undefined: DIV with B==0 runs the normal sequence, and whatever Y presents is captured with res_err=0.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_CMP..OP_MUL)
  - state encoding typedef (IDLE, LOAD_A, LOAD_B, EXEC, WAIT, DONE)
  - instruction field bit positions
  - error result constant 8'hFF
- One natural sub-module, alu_op_decode. It is combinational: opcode plus an enable in; five one-hot op strobes and an illegal flag out. The FSM asserts the enable only in EXEC.

Test Plan:
- ADD: instr=12'h235 (op1, A=3, B=5) with a datapath model attached -> ldA in cycle 1, ldB in cycle 2, aAdd in cycle 3 only, res_valid in cycle 5 with res_data=8'h08, res_err=0.
- MUL: A=4'hF, B=4'hF -> res_data=8'hE1; exactly one aMul pulse; no other op strobe ever high.
- Illegal opcode 6: instr=12'hC12 -> no ld or op strobes; res_valid in cycle 1 with res_data=0, res_err=1.
- Backpressure: hold res_ready=0 for 3 cycles after res_valid -> res_data stable, instr_ready=0; a new instr_valid is not accepted until the cycle after the res_ready handshake.
- Reset mid-EXEC: drop rst_n during the aSub pulse -> aSub=0 immediately; after release, instr_ready=1, res_valid=0, Datain=0.
- DIVZ (macro defined): DIV with B=0 -> no strobes, res_data=8'hFF, res_err=1. Macro undefined: full sequence with aDiv pulsed, res_err=0.
